// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//
// Multi-cycle MIPS control unit. Sequences each instruction through fetch,
// decode, execute, memory and write-back cycles and drives the shared
// datapath's strobes and multiplexer selects. Most outputs depend only on the
// state (Moore). IRWrite/PCWrite in FETCH follow MemReady (Mealy).
//
// A watchdog counts consecutive MemReady-low cycles in the three memory-wait
// states. On the (MAX_WAIT+1)-th consecutive stall the machine enters FAULT,
// and it stays there until reset.
//
// Build option:
//   ILLEGAL_TRAP_EN  defined   : an undefined opcode in DECODE enters FAULT.
//                    undefined : an undefined opcode is a 2-cycle NOP.
//
// Parameters:
//   ALUOP_WIDTH            width of ALUOp (>= 3)
//   ALUOP_ADD/OR/LUI/SUB/R ALUOp codes
//   MAX_WAIT               tolerated consecutive stall cycles (0 = no watchdog)
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   OP[5:0]    in   opcode from the instruction register
//   MemReady   in   memory completes the current access this cycle
//   IRWrite, PCWrite, IorD, MemRead, MemWrite, MemtoReg, RegDst, RegWrite,
//   ALUSrcA, BranchEQ, BranchNE
//              out  datapath strobes and selects
//   ALUSrcB[1:0]   out  00 B, 01 const 4, 10 sign-ext imm, 11 shifted imm
//   PCSource[1:0]  out  00 ALU result, 01 ALUOut, 10 jump target
//   ALUOp      out  ALU operation code
//   State[3:0] out  current state, for debug
//   Fault      out  high while in FAULT
// -----------------------------------------------------------------------------
module multicycle_control #(
    parameter int                     ALUOP_WIDTH = 3,
    parameter logic [ALUOP_WIDTH-1:0] ALUOP_ADD   = ALUOP_WIDTH'(3'b100),
    parameter logic [ALUOP_WIDTH-1:0] ALUOP_OR    = ALUOP_WIDTH'(3'b101),
    parameter logic [ALUOP_WIDTH-1:0] ALUOP_LUI   = ALUOP_WIDTH'(3'b011),
    parameter logic [ALUOP_WIDTH-1:0] ALUOP_SUB   = ALUOP_WIDTH'(3'b001),
    parameter logic [ALUOP_WIDTH-1:0] ALUOP_R     = ALUOP_WIDTH'(3'b111),
    parameter int                     MAX_WAIT    = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [5:0]             OP,
    input  logic                   MemReady,
    output logic                   IRWrite,
    output logic                   PCWrite,
    output logic                   IorD,
    output logic                   MemRead,
    output logic                   MemWrite,
    output logic                   MemtoReg,
    output logic                   RegDst,
    output logic                   RegWrite,
    output logic                   ALUSrcA,
    output logic                   BranchEQ,
    output logic                   BranchNE,
    output logic [1:0]             ALUSrcB,
    output logic [1:0]             PCSource,
    output logic [ALUOP_WIDTH-1:0] ALUOp,
    output logic [3:0]             State,
    output logic                   Fault
);

    // A 1-bit counter is kept even when the watchdog is disabled, so the
    // width is never zero.
    localparam int                   CNT_WIDTH = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = CNT_WIDTH'(MAX_WAIT);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        ALU_WB   = 4'd4,
        MEM_ADDR = 4'd5,
        MEM_RD   = 4'd6,
        MEM_WB   = 4'd7,
        MEM_WR   = 4'd8,
        BRANCH   = 4'd9,
        JUMP     = 4'd10,
        FAULT    = 4'd15
    } stateType;

    stateType             state, nextState;
    logic [CNT_WIDTH-1:0] waitCnt, nextWaitCnt;
    logic                 waitState;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= FETCH;
            waitCnt <= '0;
        end else begin
            state   <= nextState;
            waitCnt <= nextWaitCnt;
        end
    end

    // Next-state and watchdog logic.
    // NOTE: every signal gets a default before the case, so no path through
    // this combinational block can infer a latch.
    always_comb begin
        nextState   = state;
        nextWaitCnt = '0;
        waitState   = 1'b0;

        case (state)
            FETCH: begin
                waitState = 1'b1;
                if (MemReady) nextState = DECODE;
            end
            DECODE: begin
                case (OP)
                    OP_RTYPE:                nextState = EXEC_R;
                    OP_ADDI, OP_ORI, OP_LUI: nextState = EXEC_I;
                    OP_LW, OP_SW:            nextState = MEM_ADDR;
                    OP_BEQ, OP_BNE:          nextState = BRANCH;
                    OP_J:                    nextState = JUMP;
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        nextState = FAULT;
`else
                        nextState = FETCH;
`endif
                    end
                endcase
            end
            EXEC_R, EXEC_I: nextState = ALU_WB;
            ALU_WB:         nextState = FETCH;
            MEM_ADDR:       nextState = (OP == OP_SW) ? MEM_WR : MEM_RD;
            MEM_RD: begin
                waitState = 1'b1;
                if (MemReady) nextState = MEM_WB;
            end
            MEM_WB:         nextState = FETCH;
            MEM_WR: begin
                waitState = 1'b1;
                if (MemReady) nextState = FETCH;
            end
            BRANCH, JUMP:   nextState = FETCH;
            FAULT:          nextState = FAULT;
            default:        nextState = FAULT;
        endcase

        // A stall keeps the state, so the count carries. Any completion or
        // state change leaves nextWaitCnt at its cleared default.
        if (waitState && !MemReady) begin
            if ((MAX_WAIT != 0) && (waitCnt == CNT_MAX))
                nextState = FAULT;
            else if (waitCnt != CNT_MAX)
                nextWaitCnt = waitCnt + CNT_WIDTH'(1);
            else
                nextWaitCnt = waitCnt;
        end
    end

    // Output decode. While reset is low, every output is held at 0.
    always_comb begin
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        MemtoReg = 1'b0;
        RegDst   = 1'b0;
        RegWrite = 1'b0;
        ALUSrcA  = 1'b0;
        BranchEQ = 1'b0;
        BranchNE = 1'b0;
        ALUSrcB  = 2'b00;
        PCSource = 2'b00;
        ALUOp    = '0;
        State    = 4'd0;
        Fault    = 1'b0;

        if (reset) begin
            State = state;
            case (state)
                FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    ALUOp   = ALUOP_ADD;
                    IRWrite = MemReady;
                    PCWrite = MemReady;
                end
                DECODE: begin
                    ALUSrcB = 2'b11;
                    ALUOp   = ALUOP_ADD;
                end
                EXEC_R: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = ALUOP_R;
                end
                EXEC_I: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    case (OP)
                        OP_ORI:  ALUOp = ALUOP_OR;
                        OP_LUI:  ALUOp = ALUOP_LUI;
                        default: ALUOp = ALUOP_ADD;
                    endcase
                end
                ALU_WB: begin
                    RegWrite = 1'b1;
                    RegDst   = (OP == OP_RTYPE);
                end
                MEM_ADDR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    ALUOp   = ALUOP_ADD;
                end
                MEM_RD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                MEM_WB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                MEM_WR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                BRANCH: begin
                    ALUSrcA  = 1'b1;
                    ALUOp    = ALUOP_SUB;
                    PCSource = 2'b01;
                    BranchEQ = (OP == OP_BEQ);
                    BranchNE = (OP == OP_BNE);
                end
                JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b10;
                end
                FAULT:   Fault = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
//
// Self-checking bench for multicycle_control. The reference model expands
// each opcode into the list of states it visits. Each memory-wait state
// stays at the head of that list while MemReady is low. A run of low cycles
// longer than MAX_WAIT replaces the list with FAULT. Expected outputs come
// from a per-state table. Directed instructions run first, followed by
// randomized opcodes and MemReady.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_multicycle_control;

    localparam int MAX_WAIT = 15;

    localparam int S_FETCH = 0, S_DECODE = 1, S_EXEC_R = 2, S_EXEC_I = 3,
                   S_ALU_WB = 4, S_MEM_ADDR = 5, S_MEM_RD = 6, S_MEM_WB = 7,
                   S_MEM_WR = 8, S_BRANCH = 9, S_JUMP = 10, S_FAULT = 15;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] OP;
    logic       MemReady;
    logic       IRWrite, PCWrite, IorD, MemRead, MemWrite, MemtoReg, RegDst;
    logic       RegWrite, ALUSrcA, BranchEQ, BranchNE, Fault;
    logic [1:0] ALUSrcB, PCSource;
    logic [2:0] ALUOp;
    logic [3:0] State;

    int         numCompared   = 0;
    int         numMismatched = 0;

    int         expQ[$];
    bit         readyPlan[$];
    logic [5:0] opPlan[$];
    logic [5:0] curOp = 6'h00;
    int         lowRun = 0;

    logic [5:0] legalOps [10] = '{6'h00, 6'h08, 6'h0D, 6'h0F, 6'h23,
                                  6'h2B, 6'h04, 6'h05, 6'h02, 6'h23};
    logic [5:0] illegalOps [4] = '{6'h3F, 6'h01, 6'h10, 6'h2A};

    multicycle_control #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset), .OP(OP), .MemReady(MemReady),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .BranchEQ(BranchEQ),
        .BranchNE(BranchNE), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
        .ALUOp(ALUOp), .State(State), .Fault(Fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        numCompared++;
        if (got !== exp) begin
            numMismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Output vector order:
    // {IRWrite,PCWrite,IorD,MemRead,MemWrite,MemtoReg,RegDst,RegWrite,
    //  ALUSrcA,BranchEQ,BranchNE,ALUSrcB,PCSource,ALUOp,Fault}
    function automatic logic [31:0] actVec();
        return {13'b0, IRWrite, PCWrite, IorD, MemRead, MemWrite, MemtoReg,
                RegDst, RegWrite, ALUSrcA, BranchEQ, BranchNE, ALUSrcB,
                PCSource, ALUOp, Fault};
    endfunction

    function automatic logic [31:0] expVec(input int s, input logic [5:0] op, input bit rdy);
        logic irw = 0, pcw = 0, iord = 0, mr = 0, mw = 0, m2r = 0, rd = 0;
        logic rw = 0, sa = 0, beq = 0, bne = 0, f = 0;
        logic [1:0] sb = 2'b00, ps = 2'b00;
        logic [2:0] aop = 3'b000;
        case (s)
            S_FETCH:    begin mr = 1; sb = 2'b01; aop = 3'b100; irw = rdy; pcw = rdy; end
            S_DECODE:   begin sb = 2'b11; aop = 3'b100; end
            S_EXEC_R:   begin sa = 1; aop = 3'b111; end
            S_EXEC_I:   begin
                sa = 1; sb = 2'b10;
                aop = (op == 6'h0D) ? 3'b101 : (op == 6'h0F) ? 3'b011 : 3'b100;
            end
            S_ALU_WB:   begin rw = 1; rd = (op == 6'h00); end
            S_MEM_ADDR: begin sa = 1; sb = 2'b10; aop = 3'b100; end
            S_MEM_RD:   begin mr = 1; iord = 1; end
            S_MEM_WB:   begin rw = 1; m2r = 1; end
            S_MEM_WR:   begin mw = 1; iord = 1; end
            S_BRANCH:   begin
                sa = 1; aop = 3'b001; ps = 2'b01;
                beq = (op == 6'h04); bne = (op == 6'h05);
            end
            S_JUMP:     begin pcw = 1; ps = 2'b10; end
            S_FAULT:    f = 1;
            default:    ;
        endcase
        return {13'b0, irw, pcw, iord, mr, mw, m2r, rd, rw, sa, beq, bne, sb, ps, aop, f};
    endfunction

    task automatic pushInstr(input logic [5:0] op);
        expQ.push_back(S_FETCH);
        expQ.push_back(S_DECODE);
        case (op)
            6'h00:               begin expQ.push_back(S_EXEC_R); expQ.push_back(S_ALU_WB); end
            6'h08, 6'h0D, 6'h0F: begin expQ.push_back(S_EXEC_I); expQ.push_back(S_ALU_WB); end
            6'h23: begin
                expQ.push_back(S_MEM_ADDR); expQ.push_back(S_MEM_RD); expQ.push_back(S_MEM_WB);
            end
            6'h2B:               begin expQ.push_back(S_MEM_ADDR); expQ.push_back(S_MEM_WR); end
            6'h04, 6'h05:        expQ.push_back(S_BRANCH);
            6'h02:               expQ.push_back(S_JUMP);
            default: begin
`ifdef ILLEGAL_TRAP_EN
                expQ.push_back(S_FAULT);
`endif
            end
        endcase
    endtask

    function automatic logic [5:0] pickOp();
        if ($urandom_range(0, 19) == 0) return illegalOps[$urandom_range(0, 3)];
        return legalOps[$urandom_range(0, 9)];
    endfunction

    // Advance the model by one clock.
    task automatic stepModel(input bit rdy);
        int s;
        if (expQ.size() == 0) return;
        s = expQ[0];
        if (s == S_FAULT) return;
        if ((s == S_FETCH || s == S_MEM_RD || s == S_MEM_WR) && !rdy) begin
            lowRun++;
            if (MAX_WAIT != 0 && lowRun > MAX_WAIT) begin
                expQ.delete();
                expQ.push_back(S_FAULT);
            end
        end else begin
            lowRun = 0;
            void'(expQ.pop_front());
        end
    endtask

    // One clock: starts and ends at a falling edge.
    task automatic runCycle();
        bit rdy;
        int s;
        if (expQ.size() == 0) begin
            curOp = (opPlan.size() != 0) ? opPlan.pop_front() : pickOp();
            pushInstr(curOp);
            OP = curOp;
        end
        rdy = (readyPlan.size() != 0) ? readyPlan.pop_front() : ($urandom_range(0, 3) != 0);
        MemReady = rdy;
        #1;
        s = expQ[0];
        check("state", {28'b0, State}, 32'(s));
        check("outputs", actVec(), expVec(s, curOp, rdy));
        @(posedge clk);
        stepModel(rdy);
        @(negedge clk);
    endtask

    // Asynchronous reset pulse: starts and ends at a falling edge.
    task automatic doReset();
        reset    = 1'b0;
        MemReady = 1'b1;
        #1;
        check("rst_state", {28'b0, State}, 32'd0);
        check("rst_outputs", actVec(), 32'd0);
        @(posedge clk);
        #1;
        check("rst_hold_outputs", actVec(), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        expQ.delete();
        lowRun = 0;
    endtask

    initial begin
        reset    = 1'b0;
        MemReady = 1'b0;
        OP       = 6'h00;
        @(negedge clk);
        doReset();

        // ADDI with zero-wait memory: FETCH, DECODE, EXEC_I, ALU_WB.
        opPlan.push_back(6'h08);
        repeat (4) readyPlan.push_back(1'b1);
        repeat (4) runCycle();

        // LW with three stall cycles in MEM_RD: 8 cycles in total.
        opPlan.push_back(6'h23);
        readyPlan = '{1, 1, 1, 0, 0, 0, 1, 1};
        repeat (8) runCycle();

        // BNE, then BEQ and J.
        opPlan.push_back(6'h05);
        opPlan.push_back(6'h04);
        opPlan.push_back(6'h02);
        repeat (9) readyPlan.push_back(1'b1);
        repeat (9) runCycle();

        // Undefined opcode: a NOP, or a FAULT when trapping is enabled.
        opPlan.push_back(6'h3F);
        repeat (2) readyPlan.push_back(1'b1);
        repeat (4) runCycle();
        doReset();

        // Reset during MEM_WR aborts the store immediately.
        opPlan.push_back(6'h2B);
        readyPlan = '{1, 1, 1, 0};
        repeat (4) runCycle();
        MemReady = 1'b0;
        #1;
        check("memwr_before_reset", {31'b0, MemWrite}, 32'd1);
        doReset();

        // MemReady rises just as the counter reaches MAX_WAIT: no fault.
        opPlan.push_back(6'h00);
        repeat (MAX_WAIT) readyPlan.push_back(1'b0);
        repeat (4) readyPlan.push_back(1'b1);
        repeat (MAX_WAIT + 4) runCycle();

        // MAX_WAIT+1 stall cycles in FETCH: FAULT holds until reset.
        opPlan.push_back(6'h08);
        repeat (MAX_WAIT + 1) readyPlan.push_back(1'b0);
        repeat (MAX_WAIT + 1) runCycle();
        repeat (3) runCycle();
        doReset();

        // Randomized opcodes and MemReady.
        repeat (1500) begin
            runCycle();
            if (expQ.size() != 0 && expQ[0] == S_FAULT) begin
                runCycle();
                doReset();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
